logic_analyzer_controller: RTL and testbench

LOGIC_ANALYZER_CONTROLLER -- requirements
Module: logic_analyzer_controller

---
 rtl/logic_analyzer_controller_pkg.sv | 34 +++
 rtl/logic_analyzer_controller_regs.sv | 90 +++++++++
 rtl/logic_analyzer_controller.sv | 125 ++++++++++++
 tb/tb_logic_analyzer_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_analyzer_controller_pkg.sv
// Shared encodings for the logic analyzer controller: FSM states, trigger
// modes and register offsets.
package logic_analyzer_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE             = 3'd0,
        ST_MOVE_TO_POSITION = 3'd1,
        ST_IN_POSITION      = 3'd2,
        ST_CAPTURING        = 3'd3,
        ST_CAPTURED         = 3'd4
    } la_state_e;

    typedef enum logic [1:0] {
        MODE_SINGLE      = 2'd0,
        MODE_INCREMENTAL = 2'd1,
        MODE_IMMEDIATE   = 2'd2,
        MODE_SINGLE_ALT  = 2'd3
    } la_mode_e;

    localparam logic [15:0] REG_STATE     = 16'd0;
    localparam logic [15:0] REG_TRIG_MODE = 16'd1;
    localparam logic [15:0] REG_TRIG_LOC  = 16'd2;
    localparam logic [15:0] REG_START     = 16'd3;
    localparam logic [15:0] REG_STOP      = 16'd4;
    localparam logic [15:0] REG_WRITE_PTR = 16'd5;
    localparam logic [15:0] REG_READ_PTR  = 16'd6;
    localparam logic [15:0] NUM_REGS      = 16'd7;

    // Mode 3 is an alias of SINGLE.
    function automatic logic is_single(logic [1:0] mode);
        return (mode == MODE_SINGLE) || (mode == MODE_SINGLE_ALT);
    endfunction

endpackage

// File: rtl/logic_analyzer_controller_regs.sv
// Register file and one-cycle bus pipeline; intercepts reads that hit the
// register window and turns request_start/stop rising edges into events.
module logic_analyzer_controller_regs
    import logic_analyzer_controller_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   addr_i,
    input  logic [15:0]   wdata_i,
    input  logic [15:0]   rdata_i,
    input  logic          rw_i,
    input  logic          valid_i,
    output logic [15:0]   addr_o,
    output logic [15:0]   wdata_o,
    output logic [15:0]   rdata_o,
    output logic          rw_o,
    output logic          valid_o,
    input  la_state_e     state,
    input  logic [AW-1:0] write_pointer,
    input  logic [AW-1:0] read_pointer,
    output logic [1:0]    trigger_mode,
    output logic [AW-1:0] trigger_loc,
    output logic          start_evt,
    output logic          stop_evt
);

    logic [15:0] off;
    logic        hit;
    logic [15:0] rd_val;
    logic        request_start, request_stop;
    logic        start_q, stop_q;

    // Wrapping subtract: off < NUM_REGS exactly when addr is inside the window.
    assign off = addr_i - 16'(BASE_ADDR);
    assign hit = valid_i && (off < NUM_REGS);

    always_comb begin
        rd_val = 16'h0000;
        case (off)
            REG_STATE:     rd_val = {13'b0, state};
            REG_TRIG_MODE: rd_val = {14'b0, trigger_mode};
            REG_TRIG_LOC:  rd_val = 16'(trigger_loc);
            REG_START:     rd_val = {15'b0, request_start};
            REG_STOP:      rd_val = {15'b0, request_stop};
            REG_WRITE_PTR: rd_val = 16'(write_pointer);
            REG_READ_PTR:  rd_val = 16'(read_pointer);
            default:       rd_val = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_o        <= '0;
            wdata_o       <= '0;
            rdata_o       <= '0;
            rw_o          <= 1'b0;
            valid_o       <= 1'b0;
            trigger_mode  <= '0;
            trigger_loc   <= '0;
            request_start <= 1'b0;
            request_stop  <= 1'b0;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
        end else begin
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            rw_o    <= rw_i;
            valid_o <= valid_i;
            rdata_o <= (hit && !rw_i) ? rd_val : rdata_i;
            start_q <= request_start;
            stop_q  <= request_stop;
            if (hit && rw_i) begin
                case (off)
                    REG_TRIG_MODE: if (state == ST_IDLE) trigger_mode <= wdata_i[1:0];
                    REG_TRIG_LOC:  if (state == ST_IDLE) trigger_loc  <= wdata_i[AW-1:0];
                    REG_START:     request_start <= wdata_i[0];
                    REG_STOP:      request_stop  <= wdata_i[0];
                    default:       ;
                endcase
            end
        end
    end

    assign start_evt = request_start & ~start_q;
    assign stop_evt  = request_stop  & ~stop_q;

endmodule

// File: rtl/logic_analyzer_controller.sv
// Logic analyzer capture controller: trigger-positioning FSM and sample-memory
// write/read pointers, with the register file in a sub-module.
module logic_analyzer_controller
    import logic_analyzer_controller_pkg::*;
#(
    parameter int  BASE_ADDR    = 0,
    parameter int  SAMPLE_DEPTH = 1024,
    localparam int AW           = $clog2(SAMPLE_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   addr_i,
    input  logic [15:0]   wdata_i,
    input  logic [15:0]   rdata_i,
    input  logic          rw_i,
    input  logic          valid_i,
    output logic [15:0]   addr_o,
    output logic [15:0]   wdata_o,
    output logic [15:0]   rdata_o,
    output logic          rw_o,
    output logic          valid_o,
    input  logic          trig_i,
    output logic          we_o,
    output logic [AW-1:0] waddr_o
);

    localparam logic [AW-1:0] LAST = AW'(SAMPLE_DEPTH - 1);

    la_state_e     state, state_n;
    logic [AW-1:0] wp, wp_n, rp, rp_n;
    logic          we;
    logic [1:0]    trigger_mode;
    logic [AW-1:0] trigger_loc;
    logic          start_evt, stop_evt;

    logic_analyzer_controller_regs #(
        .BASE_ADDR(BASE_ADDR),
        .AW       (AW)
    ) u_regs (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_i      (rdata_i),
        .rw_i         (rw_i),
        .valid_i      (valid_i),
        .addr_o       (addr_o),
        .wdata_o      (wdata_o),
        .rdata_o      (rdata_o),
        .rw_o         (rw_o),
        .valid_o      (valid_o),
        .state        (state),
        .write_pointer(wp),
        .read_pointer (rp),
        .trigger_mode (trigger_mode),
        .trigger_loc  (trigger_loc),
        .start_evt    (start_evt),
        .stop_evt     (stop_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            wp    <= '0;
            rp    <= '0;
        end else begin
            state <= state_n;
            wp    <= wp_n;
            rp    <= rp_n;
        end
    end

    always_comb begin
        state_n = state;
        wp_n    = wp;
        rp_n    = rp;
        we      = 1'b0;
        // Stop wins over everything, including the write of the current cycle.
        if (stop_evt) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_evt) begin
                        wp_n = '0;
                        rp_n = '0;
                        if (is_single(trigger_mode))
                            state_n = (trigger_loc != '0) ? ST_MOVE_TO_POSITION : ST_IN_POSITION;
                        else
                            state_n = ST_CAPTURING;
                    end
                end
                ST_MOVE_TO_POSITION: begin
                    we   = 1'b1;
                    wp_n = wp + AW'(1);
                    if (wp_n == trigger_loc) state_n = ST_IN_POSITION;
                end
                ST_IN_POSITION: begin
                    // read_pointer trails the sample being written by trigger_loc.
                    we   = 1'b1;
                    wp_n = wp + AW'(1);
                    rp_n = wp - trigger_loc;
                    if (trig_i) state_n = ST_CAPTURING;
                end
                ST_CAPTURING: begin
                    we = is_single(trigger_mode) || (trigger_mode == MODE_IMMEDIATE) || trig_i;
                    if (we) begin
                        wp_n = wp + AW'(1);
                        if (is_single(trigger_mode)) begin
                            if (wp == rp - AW'(1)) state_n = ST_CAPTURED;
                        end else if (wp == LAST) begin
                            state_n = ST_CAPTURED;
                        end
                    end
                end
                ST_CAPTURED: ;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign we_o    = we & ~rst;
    assign waddr_o = wp;

endmodule

// File: tb/tb_logic_analyzer_controller.sv
// Directed bench for logic_analyzer_controller with an 8-deep sample memory.
module tb_logic_analyzer_controller;
    import logic_analyzer_controller_pkg::*;

    localparam int BASE  = 16'h0040;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i, trig_i;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o, we_o;
    logic [2:0]  waddr_o;

    int errs = 0, checks = 0, cyc = 0;
    int wlog[$];
    int wcyc[$];

    logic_analyzer_controller #(.BASE_ADDR(BASE), .SAMPLE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
        .trig_i(trig_i), .we_o(we_o), .waddr_o(waddr_o)
    );

    always #5 clk = ~clk;

    // Sample-memory write log, taken mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (we_o === 1'b1) begin
            wlog.push_back(int'(waddr_o));
            wcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int off, input logic [15:0] d);
        valid_i = 1'b1; rw_i = 1'b1; addr_i = 16'(BASE + off); wdata_i = d;
        tick;
        valid_i = 1'b0; rw_i = 1'b0;
    endtask

    task automatic read_reg(input int off, output logic [15:0] d);
        valid_i = 1'b1; rw_i = 1'b0; addr_i = 16'(BASE + off);
        tick;
        valid_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic start_cap;
        write_reg(3, 16'd0);
        write_reg(3, 16'd1);
    endtask

    task automatic stop_cap;
        write_reg(4, 16'd1);
        tick;
        write_reg(4, 16'd0);
    endtask

    initial begin
        logic [15:0] d;
        int n;
        int exp_single[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5};

        // Reset with busy inputs: nothing may leak through or get written.
        rst = 1'b1; valid_i = 1'b1; rw_i = 1'b1; addr_i = 16'(BASE + 1);
        wdata_i = 16'h0003; rdata_i = 16'h1234; trig_i = 1'b1;
        tick; tick;
        check("rst_we", we_o, 0);
        check("rst_waddr", waddr_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_rw", rw_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_rdata", rdata_o, 0);
        rst = 1'b0; valid_i = 1'b0; rw_i = 1'b0; trig_i = 1'b0;
        addr_i = 0; wdata_i = 0; rdata_i = 0;
        tick;
        read_reg(1, d); check("rst_mode", d, 0);
        read_reg(0, d); check("rst_state", d, 0);

        // Pass-through outside the register window, one cycle late.
        valid_i = 1'b1; rw_i = 1'b0; addr_i = 16'(BASE + 7); rdata_i = 16'hBEEF; wdata_i = 16'h5A5A;
        tick;
        check("pt_rdata", rdata_o, 16'hBEEF);
        check("pt_addr", addr_o, 16'h0047);
        check("pt_wdata", wdata_o, 16'h5A5A);
        check("pt_valid", valid_o, 1);
        check("pt_rw", rw_o, 0);
        valid_i = 1'b0; rdata_i = 16'h0000;
        tick;
        check("pt_valid_drop", valid_o, 0);

        // IMMEDIATE: eight back-to-back writes at 0..7.
        write_reg(1, 16'd2);
        read_reg(1, d); check("imm_mode", d, 2);
        wlog.delete(); wcyc.delete();
        start_cap;
        repeat (12) tick;
        check("imm_nwr", wlog.size(), 8);
        for (int i = 0; i < wlog.size() && i < 8; i++) begin
            check("imm_addr", wlog[i], i);
            if (i > 0) check("imm_consec", wcyc[i] - wcyc[i-1], 1);
        end
        read_reg(0, d); check("imm_state", d, 16'h0004);
        read_reg(6, d); check("imm_rp", d, 0);
        write_reg(1, 16'd1);
        read_reg(1, d); check("mode_locked", d, 2);
        stop_cap;
        read_reg(0, d); check("imm_stop_state", d, 0);

        // INCREMENTAL: writes only on the trig_i cycles.
        write_reg(1, 16'd1);
        wlog.delete(); wcyc.delete();
        start_cap;
        tick;
        for (int i = 0; i < 16; i++) begin
            trig_i = (i % 2 == 0);
            tick;
        end
        trig_i = 1'b1; tick; tick; trig_i = 1'b0;
        check("inc_nwr", wlog.size(), 8);
        for (int i = 0; i < wlog.size() && i < 8; i++) begin
            check("inc_addr", wlog[i], i);
            if (i > 0) check("inc_gap", wcyc[i] - wcyc[i-1], 2);
        end
        read_reg(0, d); check("inc_state", d, 16'h0004);
        stop_cap;

        // Mode 3 behaves as SINGLE; loc=0 goes straight to IN_POSITION. Then stop.
        write_reg(1, 16'd3);
        write_reg(2, 16'd0);
        start_cap;
        tick;
        read_reg(0, d); check("m3_state", d, 2);
        write_reg(4, 16'd1);
        tick;
        n = wlog.size();
        check("stop_we", we_o, 0);
        read_reg(0, d); check("stop_state", d, 0);
        write_reg(4, 16'd0);
        write_reg(2, 16'd5);
        read_reg(2, d); check("loc_idle_wr", d, 5);
        check("stop_nowr", wlog.size(), n);

        // SINGLE, trigger_loc=3, trigger 10 cycles after start.
        write_reg(2, 16'd3);
        write_reg(1, 16'd0);
        wlog.delete(); wcyc.delete();
        start_cap;
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) write_reg(2, 16'd5);
            else tick;
        end
        trig_i = 1'b1;
        #1;
        check("sgl_trig_we", we_o, 1);
        check("sgl_trig_addr", waddr_o, 1);
        tick;
        trig_i = 1'b0;
        repeat (8) tick;
        check("sgl_nwr", wlog.size(), 14);
        for (int i = 0; i < wlog.size() && i < 14; i++) check("sgl_seq", wlog[i], exp_single[i]);
        read_reg(0, d); check("sgl_state", d, 16'h0004);
        read_reg(6, d); check("sgl_rp", d, 6);
        read_reg(5, d); check("sgl_wp", d, 6);
        read_reg(2, d); check("loc_busy_wr", d, 3);
        if (wlog.size() > 0) check("sgl_last", wlog[wlog.size()-1], 5);
        stop_cap;

        // Reset in the middle of an IMMEDIATE capture.
        write_reg(1, 16'd2);
        start_cap;
        tick; tick; tick;
        check("cap_we", we_o, 1);
        n = wlog.size();
        rst = 1'b1; valid_i = 1'b1; rw_i = 1'b0; addr_i = 16'(BASE); rdata_i = 16'h7777;
        tick;
        check("mrst_we", we_o, 0);
        check("mrst_waddr", waddr_o, 0);
        check("mrst_valid", valid_o, 0);
        check("mrst_addr", addr_o, 0);
        check("mrst_rdata", rdata_o, 0);
        check("mrst_nowr", wlog.size(), n);
        rst = 1'b0; valid_i = 1'b0; rdata_i = 16'h0000;
        tick;
        read_reg(0, d); check("mrst_state", d, 0);
        read_reg(1, d); check("mrst_mode", d, 0);
        read_reg(3, d); check("mrst_start", d, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
